// File: rtl/adma_axi_pkg.sv
// Shared AXI response encodings, burst-response merge rule and accumulator states.
// Optional macro ADMA_SL_B_EXOKAY_EN makes EXOKAY a legal merged result.
package adma_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_BURST = 1'b1
  } acc_state_e;

  // Errors dominate; EXOKAY survives only if both sides are EXOKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = RESP_OKAY;
    if (a == RESP_DECERR || b == RESP_DECERR) begin
      r = RESP_DECERR;
    end else if (a == RESP_SLVERR || b == RESP_SLVERR) begin
      r = RESP_SLVERR;
`ifdef ADMA_SL_B_EXOKAY_EN
    end else if (a == RESP_EXOKAY && b == RESP_EXOKAY) begin
      r = RESP_EXOKAY;
`endif
    end else begin
      r = RESP_OKAY;
    end
    return r;
  endfunction

endpackage

// File: rtl/adma_sl_axi_b_if.sv
// AW-ID push, W-beat status and B-channel signals of the slave write-response generator.
interface adma_sl_axi_b_if #(
  parameter int unsigned SLV_ID_W   = 5,
  parameter int unsigned ATX_RESP_W = 2
);
  logic [SLV_ID_W-1:0]   aw_id_i;
  logic                  aw_vld_i;
  logic                  aw_rdy_o;
  logic [ATX_RESP_W-1:0] wr_beat_resp_i;
  logic                  wr_beat_last_i;
  logic                  wr_beat_vld_i;
  logic                  wr_beat_rdy_o;
  logic [SLV_ID_W-1:0]   s_bid_o;
  logic [ATX_RESP_W-1:0] s_bresp_o;
  logic                  s_bvalid_o;
  logic                  s_bready_i;

  modport slave (
    input  aw_id_i, aw_vld_i, wr_beat_resp_i, wr_beat_last_i, wr_beat_vld_i, s_bready_i,
    output aw_rdy_o, wr_beat_rdy_o, s_bid_o, s_bresp_o, s_bvalid_o
  );

  modport master (
    output aw_id_i, aw_vld_i, wr_beat_resp_i, wr_beat_last_i, wr_beat_vld_i, s_bready_i,
    input  aw_rdy_o, wr_beat_rdy_o, s_bid_o, s_bresp_o, s_bvalid_o
  );
endinterface

// File: rtl/adma_sl_axi_b_idq.sv
// In-order AW ID queue; a push is refused while full even if a pop happens the same cycle.
module adma_sl_axi_b_idq #(
  parameter int unsigned DataW = 5,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             pop_i,
  output logic [DataW-1:0] data_o,
  output logic [CntW-1:0]  cnt_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/adma_sl_axi_b.sv
// Slave-side AXI B-channel generator: pairs queued AW IDs with completed W bursts.
// Build option: ADMA_SL_B_EXOKAY_EN allows EXOKAY as a merged burst response.
module adma_sl_axi_b
  import adma_axi_pkg::*;
#(
  parameter int unsigned SLV_ID_W       = 5,
  parameter int unsigned ATX_RESP_W     = 2,
  parameter int unsigned ATX_NUM_OSTD   = 4,
  parameter int unsigned ATX_NUM_OSTD_W = $clog2(ATX_NUM_OSTD) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  adma_sl_axi_b_if.slave            bus,
  output logic [ATX_NUM_OSTD_W-1:0] ostd_cnt_o
);

  logic                  idq_full, idq_empty;
  logic [SLV_ID_W-1:0]   head_id;
  logic                  beat_hs, issue;
  logic [ATX_RESP_W-1:0] merged_nxt;

  acc_state_e            acc_q;
  logic [ATX_RESP_W-1:0] merged_q;
  logic                  bvalid_q;
  logic [SLV_ID_W-1:0]   bid_q;
  logic [ATX_RESP_W-1:0] bresp_q;

  adma_sl_axi_b_idq #(
    .DataW (SLV_ID_W),
    .Depth (ATX_NUM_OSTD),
    .CntW  (ATX_NUM_OSTD_W)
  ) u_idq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.aw_vld_i),
    .data_i  (bus.aw_id_i),
    .pop_i   (issue),
    .data_o  (head_id),
    .cnt_o   (ostd_cnt_o),
    .full_o  (idq_full),
    .empty_o (idq_empty)
  );

  // Beats wait for a queued ID and for room in the output register.
  assign bus.aw_rdy_o      = ~idq_full;
  assign bus.wr_beat_rdy_o = ~idq_empty & (~bvalid_q | bus.s_bready_i);

  assign beat_hs = bus.wr_beat_vld_i & bus.wr_beat_rdy_o;
  assign issue   = beat_hs & bus.wr_beat_last_i;

  // Self-merge of the first beat normalises EXOKAY when the option is off.
  always_comb begin
    merged_nxt = RESP_OKAY;
    if (acc_q == ACC_IDLE) merged_nxt = resp_merge(bus.wr_beat_resp_i, bus.wr_beat_resp_i);
    else                   merged_nxt = resp_merge(merged_q, bus.wr_beat_resp_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= ACC_IDLE;
      merged_q <= RESP_OKAY;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (beat_hs) begin
        if (bus.wr_beat_last_i) begin
          acc_q    <= ACC_IDLE;
          merged_q <= RESP_OKAY;
        end else begin
          acc_q    <= ACC_BURST;
          merged_q <= merged_nxt;
        end
      end
      if (issue) begin
        bvalid_q <= 1'b1;
        bid_q    <= head_id;
        bresp_q  <= merged_nxt;
      end else if (bvalid_q && bus.s_bready_i) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign bus.s_bvalid_o = bvalid_q;
  assign bus.s_bid_o    = bid_q;
  assign bus.s_bresp_o  = bresp_q;

endmodule

// File: tb/tb_adma_sl_axi_b.sv
// Directed plus randomized bench for adma_sl_axi_b against a queue-based reference model.
module tb_adma_sl_axi_b;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ostd_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [4:0] idq_m[$];
  logic [1:0] burst_m[$];
  logic       exp_bvalid = 1'b0;
  logic [4:0] exp_bid    = '0;
  logic [1:0] exp_bresp  = '0;

  adma_sl_axi_b_if #(.SLV_ID_W(5), .ATX_RESP_W(2)) bus ();

  adma_sl_axi_b #(
    .SLV_ID_W     (5),
    .ATX_RESP_W   (2),
    .ATX_NUM_OSTD (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .ostd_cnt_o (ostd_cnt)
  );

  always #5 clk = ~clk;

  // Burst response from the whole list of beat statuses.
  function automatic logic [1:0] ref_burst_resp();
    bit any_dec = 1'b0;
    bit any_slv = 1'b0;
    bit all_ex  = 1'b1;
    foreach (burst_m[i]) begin
      if (burst_m[i] == 2'b11) any_dec = 1'b1;
      if (burst_m[i] == 2'b10) any_slv = 1'b1;
      if (burst_m[i] != 2'b01) all_ex = 1'b0;
    end
    if (any_dec) return 2'b11;
    if (any_slv) return 2'b10;
`ifdef ADMA_SL_B_EXOKAY_EN
    if (all_ex) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit awv, input logic [4:0] awid, input bit bv, input logic [1:0] r,
                      input bit last, input bit brdy);
    bit exp_awrdy, exp_wrdy, beat_acc, aw_acc;
    bus.aw_vld_i       = awv;
    bus.aw_id_i        = awid;
    bus.wr_beat_vld_i  = bv;
    bus.wr_beat_resp_i = r;
    bus.wr_beat_last_i = last;
    bus.s_bready_i     = brdy;
    @(negedge clk);
    exp_awrdy = (idq_m.size() < 4);
    exp_wrdy  = (idq_m.size() > 0) && (!exp_bvalid || brdy);
    chk("aw_rdy", 32'(bus.aw_rdy_o), 32'(exp_awrdy));
    chk("wr_beat_rdy", 32'(bus.wr_beat_rdy_o), 32'(exp_wrdy));
    chk("bvalid", 32'(bus.s_bvalid_o), 32'(exp_bvalid));
    chk("bid", 32'(bus.s_bid_o), 32'(exp_bid));
    chk("bresp", 32'(bus.s_bresp_o), 32'(exp_bresp));
    chk("ostd_cnt", 32'(ostd_cnt), 32'(idq_m.size()));
    beat_acc = bv && exp_wrdy;
    aw_acc   = awv && exp_awrdy;
    if (exp_bvalid && brdy) exp_bvalid = 1'b0;
    if (beat_acc) begin
      burst_m.push_back(r);
      if (last) begin
        exp_bid    = idq_m.pop_front();
        exp_bresp  = ref_burst_resp();
        exp_bvalid = 1'b1;
        burst_m.delete();
      end
    end
    if (aw_acc) idq_m.push_back(awid);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [4:0] id);
    step(1'b1, id, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic beat(input logic [1:0] r, input bit last, input bit brdy);
    step(1'b0, 5'd0, 1'b1, r, last, brdy);
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.aw_vld_i       = 1'b0;
    bus.aw_id_i        = '0;
    bus.wr_beat_vld_i  = 1'b0;
    bus.wr_beat_resp_i = '0;
    bus.wr_beat_last_i = 1'b0;
    bus.s_bready_i     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idq_m.delete();
    burst_m.delete();
    exp_bvalid = 1'b0;
    exp_bid    = '0;
    exp_bresp  = '0;
  endtask

  initial begin
    do_reset();
    idle(2);

    // In-order pairing, two 4-beat OKAY bursts.
    push(5'd3);
    push(5'd7);
    for (int b = 0; b < 2; b++) begin
      beat(2'b00, 1'b0, 1'b1);
      beat(2'b00, 1'b0, 1'b1);
      beat(2'b00, 1'b0, 1'b1);
      beat(2'b00, 1'b1, 1'b1);
    end
    idle(2);

    // Error merge.
    push(5'd5);
    beat(2'b00, 1'b0, 1'b1);
    beat(2'b10, 1'b0, 1'b1);
    beat(2'b11, 1'b0, 1'b1);
    beat(2'b00, 1'b1, 1'b1);
    push(5'd6);
    beat(2'b00, 1'b0, 1'b1);
    beat(2'b10, 1'b1, 1'b1);
    idle(2);

    // Queue full, then B backpressure.
    push(5'd1);
    push(5'd2);
    push(5'd4);
    push(5'd8);
    push(5'd10);
    beat(2'b00, 1'b1, 1'b0);
    beat(2'b10, 1'b1, 1'b0);
    beat(2'b10, 1'b1, 1'b0);
    beat(2'b10, 1'b1, 1'b0);
    beat(2'b10, 1'b1, 1'b1);
    idle(1);
    beat(2'b00, 1'b1, 1'b1);
    beat(2'b11, 1'b1, 1'b1);
    idle(2);

    // W before AW.
    beat(2'b00, 1'b1, 1'b1);
    beat(2'b00, 1'b1, 1'b1);
    step(1'b1, 5'd9, 1'b1, 2'b00, 1'b1, 1'b1);
    beat(2'b00, 1'b1, 1'b1);
    idle(2);

    // Reset mid-burst; the following burst must not inherit the DECERR.
    push(5'd11);
    beat(2'b00, 1'b0, 1'b1);
    beat(2'b11, 1'b0, 1'b1);
    do_reset();
    idle(1);
    push(5'd12);
    beat(2'b00, 1'b1, 1'b1);
    idle(2);

    // EXOKAY handling.
    push(5'd13);
    beat(2'b01, 1'b0, 1'b1);
    beat(2'b01, 1'b0, 1'b1);
    beat(2'b01, 1'b1, 1'b1);
    push(5'd14);
    beat(2'b01, 1'b0, 1'b1);
    beat(2'b00, 1'b1, 1'b1);
    push(5'd15);
    beat(2'b01, 1'b1, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom), ($urandom_range(0, 3) != 0),
           2'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
